// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a registered 4:1 data mux
// Optional hold-time preemption: define ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       grant,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       last;
  logic [7:0]       req_dbl;
  logic [3:0]       req_rot;
  logic [1:0]       offset;
  logic [1:0]       winner;
  logic             keep;
  logic [WIDTH-1:0] sel_data;

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("MAX_HOLD must be at least 2");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);
  logic [CW-1:0] hold_cnt;
  logic          others_pending;
`endif

  // Rotate requests so bit 0 is the requester just after the last winner.
  always_comb begin
    req_dbl = {req, req};
    req_rot = 4'(req_dbl >> ({1'b0, last} + 3'd1));
    offset  = 2'd0;
    if (req_rot[0])      offset = 2'd0;
    else if (req_rot[1]) offset = 2'd1;
    else if (req_rot[2]) offset = 2'd2;
    else if (req_rot[3]) offset = 2'd3;
    winner = last + 2'd1 + offset;
  end

  always_comb begin
`ifdef ARB_TIMEOUT_EN
    others_pending = (req & ~grant) != 4'b0000;
    keep = (state == BUSY) && req[s] &&
           !((hold_cnt == CW'(MAX_HOLD - 1)) && others_pending);
`else
    keep = (state == BUSY) && req[s];
`endif
  end

  always_comb begin
    case (s)
      2'd0:    sel_data = a;
      2'd1:    sel_data = b;
      2'd2:    sel_data = c;
      default: sel_data = d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 2'd3;
      grant   <= 4'b0000;
      s       <= 2'd0;
      y       <= '0;
      y_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      y_valid <= (state == BUSY);
      if (state == BUSY) y <= sel_data;

      if (keep) begin
`ifdef ARB_TIMEOUT_EN
        if (hold_cnt != CW'(MAX_HOLD - 1)) hold_cnt <= hold_cnt + 1'b1;
`endif
      end else if (req != 4'b0000) begin
        state <= BUSY;
        grant <= 4'b0001 << winner;
        s     <= winner;
        last  <= winner;
`ifdef ARB_TIMEOUT_EN
        hold_cnt <= '0;
`endif
      end else begin
        // s deliberately keeps its value when going idle.
        state <= IDLE;
        grant <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - randomized model-based bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [2:0] a = '0, b = '0, c = '0, d = '0;
  logic [3:0] grant;
  logic [1:0] s;
  logic [2:0] y;
  logic       y_valid;

  int tests = 0;
  int fails = 0;

  int         m_owner;
  int         m_s;
  int         m_ptr;
  logic [2:0] m_y;
  logic       m_yv;

  mux4_rr_arbiter #(.WIDTH(3), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
    .grant(grant), .s(s), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] data_of(input int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  // Reference: owner index (-1 idle), pointer to last winner, one-cycle data pipe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_s     = 0;
      m_ptr   = 3;
      m_y     = '0;
      m_yv    = 1'b0;
    end else begin
      if (m_owner >= 0) begin
        m_y  = data_of(m_s);
        m_yv = 1'b1;
      end else begin
        m_yv = 1'b0;
      end
      if (m_owner < 0 || !req[m_owner]) begin
        m_owner = -1;
        for (int k = 1; k <= 4; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
        if (m_owner >= 0) begin
          m_s   = m_owner;
          m_ptr = m_owner;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("grant", grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("s", s, m_s);
      chk("y_valid", y_valid, m_yv);
      if (m_yv) chk("y", y, m_y);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_grant", grant, 0);
    chk("reset_s", s, 0);
    chk("reset_y", y, 0);
    chk("reset_y_valid", y_valid, 0);
    rst = 1'b0;

    // single request on c
    c = 3'b101;
    req = 4'b0100;
    tick();
    chk("single_grant", grant, 4'b0100);
    chk("single_s", s, 2);
    tick();
    chk("single_y", y, 3'b101);
    chk("single_y_valid", y_valid, 1);

    // all requests drop while busy
    req = 4'b0000;
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_s", s, 2);
    chk("idle_y_valid_lag", y_valid, 1);
    tick();
    chk("idle_y_valid", y_valid, 0);
    chk("idle_s_kept", s, 2);

    // asynchronous reset mid-cycle while granted
    req = 4'b0001;
    tick();
    chk("pre_rst_grant", grant, 4'b0001);
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("async_grant", grant, 0);
    chk("async_s", s, 0);
    chk("async_y", y, 0);
    chk("async_y_valid", y_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fairness: all request, each grantee drops for one cycle
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fair_grant", grant, 32'd1 << (i % 4));
      req = 4'b1111 & ~(4'b0001 << (i % 4));
    end
    req = 4'b0000;
    repeat (2) tick();

    // handover from 1: 3 wins before 0
    req = 4'b0010;
    tick();
    chk("hand_grant1", grant, 4'b0010);
    req = 4'b1001;
    tick();
    chk("hand_grant3", grant, 4'b1000);
    chk("hand_s", s, 3);
    req = 4'b0000;
    repeat (2) tick();

    // no preemption in the default build: 0 keeps the grant
    req = 4'b0011;
    repeat (20) begin
      tick();
      chk("hold_grant0", grant, 4'b0001);
    end
    req = 4'b0000;
    tick();

    // randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 800; n++) begin
      a = 3'($urandom);
      b = 3'($urandom);
      c = 3'($urandom);
      d = 3'($urandom);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) req[k] = ~req[k];
      end
      if ($urandom_range(0, 99) == 0) begin
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
